dmem_port_arbiter: RTL

- Shares the single-port 8-bit DataMemory between two requesters: the pipeline memory stage (primary) and an auxiliary master (program loader / debug port).
- Pipeline has priority. A starvation counter guarantees the aux master a slot, and a short lock mode lets the aux master do atomic read-modify-write.
- When aux takes the port while the pipeline is requesting, the arbiter stalls the pipeline for that cycle.

---
 rtl/dmem_arb_pkg.sv | 7 +
 rtl/arb_sat_counter.sv | 17 +
 rtl/dmem_port_arbiter.sv | 88 ++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state/grant encodings and counter widths for dmem_port_arbiter
package dmem_arb_pkg;
  localparam int CNT_W = 4;
  localparam int STAT_W = 16;
  typedef enum logic {IDLE, LOCKED} arb_state_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_PIPE, GNT_AUX} gnt_e;
endpackage

// File: rtl/arb_sat_counter.sv
// arb_sat_counter: saturating up counter; clr together with inc restarts the count at 1
module arb_sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt_q
);
  logic [W-1:0] base, cnt_d;
  always_comb begin
    base = clr ? '0 : cnt_q;
    cnt_d = (inc && base != '1) ? base + W'(1) : base;
  end
  always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares DataMemory between the pipeline (priority) and an aux master with starvation guard and lock.
// Define DMEM_ARB_STATS_EN to add saturating stall_count / aux_count statistics ports.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_wen,
  input  logic              pipe_ren,
  input  logic [7:0]        pipe_addr,
  input  logic [7:0]        pipe_wdata,
  output logic [7:0]        pipe_rdata,
  output logic              pipe_stall,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic              aux_lock,
  input  logic [7:0]        aux_addr,
  input  logic [7:0]        aux_wdata,
  output logic              aux_gnt,
  output logic [7:0]        aux_rdata,
  output logic              aux_rvalid,
`ifdef DMEM_ARB_STATS_EN
  output logic [STAT_W-1:0] stall_count,
  output logic [STAT_W-1:0] aux_count,
`endif
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [7:0]        mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);
  localparam int LW = CNT_W + 1;
  arb_state_e state_q, state_d;
  gnt_e gnt;
  logic pipe_req, lock_hold, aux_rvalid_q, aux_rvalid_d;
  logic [7:0] aux_rdata_q, aux_rdata_d;
  logic [CNT_W-1:0] starve_q, lock_q;
  logic [LW-1:0] lock_nxt;
  always_comb begin
    pipe_req = pipe_wen | pipe_ren;
    gnt = !rst_n ? GNT_NONE
        : (aux_req && (state_q == LOCKED || !pipe_req || starve_q >= CNT_W'(STARVE_LIMIT))) ? GNT_AUX
        : pipe_req ? GNT_PIPE : GNT_NONE;
    aux_gnt = gnt == GNT_AUX;
    pipe_stall = pipe_req & aux_gnt;
    mem_wen = aux_gnt ? aux_we : (gnt == GNT_PIPE && pipe_wen);
    mem_ren = aux_gnt ? !aux_we : (gnt == GNT_PIPE && pipe_ren && !pipe_wen);
    mem_addr = aux_gnt ? aux_addr : gnt == GNT_PIPE ? pipe_addr : '0;
    mem_wdata = aux_gnt ? aux_wdata : gnt == GNT_PIPE ? pipe_wdata : '0;
    // lock_nxt counts locked grants including this one; reaching LOCK_MAX releases the lock
    lock_nxt = (state_q == LOCKED ? {1'b0, lock_q} : '0) + LW'(1);
    lock_hold = aux_gnt && aux_lock && lock_nxt < LW'(LOCK_MAX);
    state_d = lock_hold ? LOCKED : IDLE;
    aux_rvalid_d = aux_gnt && !aux_we;
    aux_rdata_d = aux_rvalid_d ? mem_rdata : aux_rdata_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      aux_rvalid_q <= 1'b0;
      aux_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      aux_rvalid_q <= aux_rvalid_d;
      aux_rdata_q <= aux_rdata_d;
    end
  end
  assign pipe_rdata = mem_rdata;
  assign aux_rvalid = aux_rvalid_q;
  assign aux_rdata = aux_rdata_q;
  arb_sat_counter #(.W(CNT_W)) u_starve (
    .clk, .rst_n, .clr(aux_gnt | !aux_req), .inc(aux_req & !aux_gnt), .cnt_q(starve_q)
  );
  arb_sat_counter #(.W(CNT_W)) u_lock (
    .clk, .rst_n, .clr(state_q == IDLE), .inc(aux_gnt & aux_lock), .cnt_q(lock_q)
  );
`ifdef DMEM_ARB_STATS_EN
  arb_sat_counter #(.W(STAT_W)) u_stall_stat (
    .clk, .rst_n, .clr(1'b0), .inc(pipe_stall), .cnt_q(stall_count)
  );
  arb_sat_counter #(.W(STAT_W)) u_aux_stat (
    .clk, .rst_n, .clr(1'b0), .inc(aux_gnt), .cnt_q(aux_count)
  );
`endif
endmodule
